// File: rtl/cdma_mc_pkg.sv
// Shared types and width helpers for the multi-channel CDMA descriptor front-end.
package cdma_mc_pkg;

  localparam int HBM_ADDR_BITS = 48;
  localparam int HBM_LEN_BITS  = 32;
  localparam int CH_BITS_MAX   = 4;

  typedef logic [CH_BITS_MAX-1:0] ch_t;

  typedef struct packed {
    logic [HBM_ADDR_BITS-1:0] paddr;
    logic [HBM_LEN_BITS-1:0]  len;
    ch_t                      ch;
  } desc_t;

  // Outstanding counter must be able to hold the value max_out itself.
  function automatic int cnt_bits(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  function automatic int ch_bits(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/cdma_mc_dir.sv
// One direction of the descriptor front-end: round-robin arbiter, one-deep issue
// slot, in-order channel-tag FIFO and outstanding-credit counter.
module cdma_mc_dir
  import cdma_mc_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int ADDR_BITS       = HBM_ADDR_BITS,
  parameter int LEN_BITS        = HBM_LEN_BITS,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           req_valid,
  output logic [N_CH-1:0]           req_ready,
  input  logic [N_CH*ADDR_BITS-1:0] req_paddr,
  input  logic [N_CH*LEN_BITS-1:0]  req_len,
  output logic [N_CH-1:0]           done,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [ADDR_BITS-1:0]      m_paddr,
  output logic [LEN_BITS-1:0]       m_len,
  input  logic                      m_done,
  output logic                      err
);
  localparam int CHW = ch_bits(N_CH);
  localparam int CW  = cnt_bits(MAX_OUTSTANDING);
  localparam int PW  = $clog2(MAX_OUTSTANDING);

  logic                 slot_valid_reg;
  logic [ADDR_BITS-1:0] slot_paddr_reg;
  logic [LEN_BITS-1:0]  slot_len_reg;
  logic [CHW-1:0]       slot_ch_reg;
  logic [CHW-1:0]       rr_reg;
  logic [CW-1:0]        cnt_reg;
  logic [PW-1:0]        wr_ptr_reg;
  logic [PW-1:0]        rd_ptr_reg;
  logic [CHW-1:0]       tag_mem [MAX_OUTSTANDING];
  logic [N_CH-1:0]      done_reg;
  logic                 err_reg;

  logic           issue;
  logic           pop;
  logic           can_load;
  logic           credit_ok;
  logic           grant_valid;
  logic [CHW-1:0] grant_ch;

  assign issue    = slot_valid_reg && m_ready;
  assign pop      = m_done && (cnt_reg != '0);
  assign can_load = !slot_valid_reg || issue;
  // A descriptor leaving the slot this cycle already consumes a credit.
  assign credit_ok = (int'(cnt_reg) + int'(issue)) < MAX_OUTSTANDING;

  // Lowest rotated offset from rr_reg wins; the descending loop lets it overwrite.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_ch    = '0;
    if (rst_n && can_load && credit_ok) begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        idx = int'(rr_reg) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (req_valid[CHW'(idx)]) begin
          grant_valid = 1'b1;
          grant_ch    = CHW'(idx);
        end
      end
    end
  end

  assign req_ready = grant_valid ? (N_CH'(1) << grant_ch) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid_reg <= 1'b0;
      rr_reg         <= '0;
      cnt_reg        <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      done_reg       <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (can_load) slot_valid_reg <= grant_valid;
      if (grant_valid) rr_reg <= (int'(grant_ch) == N_CH - 1) ? '0 : grant_ch + 1'b1;
      if (issue) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      cnt_reg  <= cnt_reg + CW'(issue) - CW'(pop);
      done_reg <= pop ? (N_CH'(1) << tag_mem[rd_ptr_reg]) : '0;
      if (m_done && (cnt_reg == '0)) err_reg <= 1'b1;
    end
  end

  // Payload and tag storage carry no reset; slot_valid_reg and the pointers qualify them.
  always_ff @(posedge clk) begin
    if (grant_valid) begin
      slot_paddr_reg <= req_paddr[int'(grant_ch)*ADDR_BITS +: ADDR_BITS];
      slot_len_reg   <= req_len[int'(grant_ch)*LEN_BITS +: LEN_BITS];
      slot_ch_reg    <= grant_ch;
    end
    if (issue) tag_mem[wr_ptr_reg] <= slot_ch_reg;
  end

  assign m_valid = slot_valid_reg;
  assign m_paddr = slot_paddr_reg;
  assign m_len   = slot_len_reg;
  assign done    = done_reg;
  assign err     = err_reg;

endmodule

// File: rtl/cdma_mc_ctrl.sv
// Multi-channel descriptor front-end for the CDMA: independent read and write directions.
// Optional per-channel completion counters are enabled with `define CDMA_MC_STATS_EN.
module cdma_mc_ctrl
  import cdma_mc_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int ADDR_BITS       = HBM_ADDR_BITS,
  parameter int LEN_BITS        = HBM_LEN_BITS,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N_CH-1:0]           rd_valid,
  output logic [N_CH-1:0]           rd_ready,
  input  logic [N_CH*ADDR_BITS-1:0] rd_paddr,
  input  logic [N_CH*LEN_BITS-1:0]  rd_len,
  output logic [N_CH-1:0]           rd_done,
  input  logic [N_CH-1:0]           wr_valid,
  output logic [N_CH-1:0]           wr_ready,
  input  logic [N_CH*ADDR_BITS-1:0] wr_paddr,
  input  logic [N_CH*LEN_BITS-1:0]  wr_len,
  output logic [N_CH-1:0]           wr_done,
  output logic                      m_rd_valid,
  input  logic                      m_rd_ready,
  output logic [ADDR_BITS-1:0]      m_rd_paddr,
  output logic [LEN_BITS-1:0]       m_rd_len,
  input  logic                      m_rd_done,
  output logic                      m_wr_valid,
  input  logic                      m_wr_ready,
  output logic [ADDR_BITS-1:0]      m_wr_paddr,
  output logic [LEN_BITS-1:0]       m_wr_len,
  input  logic                      m_wr_done,
  output logic [1:0]                err
`ifdef CDMA_MC_STATS_EN
  ,
  input  logic [ch_bits(N_CH)-1:0]  stat_sel,
  output logic [31:0]               stat_rd_cnt,
  output logic [31:0]               stat_wr_cnt
`endif
);

  logic rd_err;
  logic wr_err;

  cdma_mc_dir #(
    .N_CH           (N_CH),
    .ADDR_BITS      (ADDR_BITS),
    .LEN_BITS       (LEN_BITS),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_rd (
    .clk      (aclk),
    .rst_n    (aresetn),
    .req_valid(rd_valid),
    .req_ready(rd_ready),
    .req_paddr(rd_paddr),
    .req_len  (rd_len),
    .done     (rd_done),
    .m_valid  (m_rd_valid),
    .m_ready  (m_rd_ready),
    .m_paddr  (m_rd_paddr),
    .m_len    (m_rd_len),
    .m_done   (m_rd_done),
    .err      (rd_err)
  );

  cdma_mc_dir #(
    .N_CH           (N_CH),
    .ADDR_BITS      (ADDR_BITS),
    .LEN_BITS       (LEN_BITS),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_wr (
    .clk      (aclk),
    .rst_n    (aresetn),
    .req_valid(wr_valid),
    .req_ready(wr_ready),
    .req_paddr(wr_paddr),
    .req_len  (wr_len),
    .done     (wr_done),
    .m_valid  (m_wr_valid),
    .m_ready  (m_wr_ready),
    .m_paddr  (m_wr_paddr),
    .m_len    (m_wr_len),
    .m_done   (m_wr_done),
    .err      (wr_err)
  );

  assign err = {wr_err, rd_err};

`ifdef CDMA_MC_STATS_EN
  logic [31:0] rd_stat_reg [N_CH];
  logic [31:0] wr_stat_reg [N_CH];

  // Counters follow the registered done pulses, so they lag completion by one cycle.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int c = 0; c < N_CH; c++) begin
        rd_stat_reg[c] <= '0;
        wr_stat_reg[c] <= '0;
      end
      stat_rd_cnt <= '0;
      stat_wr_cnt <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (rd_done[c]) rd_stat_reg[c] <= rd_stat_reg[c] + 32'd1;
        if (wr_done[c]) wr_stat_reg[c] <= wr_stat_reg[c] + 32'd1;
      end
      stat_rd_cnt <= rd_stat_reg[stat_sel];
      stat_wr_cnt <= wr_stat_reg[stat_sel];
    end
  end
`endif

endmodule

// File: tb/tb_cdma_mc_ctrl.sv
// Randomized self-checking bench for cdma_mc_ctrl against a queue-based reference model.
// Build with CDMA_MC_STATS_EN defined to also check the per-channel completion counters.
module tb_cdma_mc_ctrl;
  import cdma_mc_pkg::*;

  localparam int N  = 4;
  localparam int AW = HBM_ADDR_BITS;
  localparam int LW = HBM_LEN_BITS;
  localparam int MO = 8;
  localparam int QD = 256;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  // stimulus, index 0 = read direction, 1 = write direction
  logic [N-1:0]  req_valid [2];
  logic [AW-1:0] req_addr  [2][N];
  logic [LW-1:0] req_len   [2][N];
  logic          m_ready   [2];
  logic          m_done    [2];

  wire  [N-1:0]   rd_valid, wr_valid;
  logic [N-1:0]   rd_ready, wr_ready, rd_done, wr_done;
  wire  [N*AW-1:0] rd_paddr, wr_paddr;
  wire  [N*LW-1:0] rd_len, wr_len;
  wire            m_rd_ready, m_rd_done, m_wr_ready, m_wr_done;
  logic           m_rd_valid, m_wr_valid;
  logic [AW-1:0]  m_rd_paddr, m_wr_paddr;
  logic [LW-1:0]  m_rd_len, m_wr_len;
  logic [1:0]     err;
`ifdef CDMA_MC_STATS_EN
  logic [1:0]     stat_sel;
  logic [31:0]    stat_rd_cnt, stat_wr_cnt;
`endif

  assign rd_valid   = req_valid[0];
  assign wr_valid   = req_valid[1];
  assign m_rd_ready = m_ready[0];
  assign m_wr_ready = m_ready[1];
  assign m_rd_done  = m_done[0];
  assign m_wr_done  = m_done[1];

  for (genvar gi = 0; gi < N; gi++) begin : g_flat
    assign rd_paddr[gi*AW +: AW] = req_addr[0][gi];
    assign wr_paddr[gi*AW +: AW] = req_addr[1][gi];
    assign rd_len[gi*LW +: LW]   = req_len[0][gi];
    assign wr_len[gi*LW +: LW]   = req_len[1][gi];
  end

  cdma_mc_ctrl #(
    .N_CH(N), .ADDR_BITS(AW), .LEN_BITS(LW), .MAX_OUTSTANDING(MO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_paddr(rd_paddr), .rd_len(rd_len), .rd_done(rd_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_paddr(wr_paddr), .wr_len(wr_len), .wr_done(wr_done),
    .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_paddr(m_rd_paddr),
    .m_rd_len(m_rd_len), .m_rd_done(m_rd_done),
    .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready), .m_wr_paddr(m_wr_paddr),
    .m_wr_len(m_wr_len), .m_wr_done(m_wr_done),
    .err(err)
`ifdef CDMA_MC_STATS_EN
    , .stat_sel(stat_sel), .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: slot contents, issue-ordered tag list, rr position, completions.
  bit            mdl_slot_v    [2];
  logic [AW-1:0] mdl_slot_addr [2];
  logic [LW-1:0] mdl_slot_len  [2];
  int            mdl_slot_ch   [2];
  int            mdl_tags      [2][QD];
  int            mdl_head      [2];
  int            mdl_tail      [2];
  int            mdl_rr        [2];
  logic [N-1:0]  mdl_done      [2];
  bit            mdl_err       [2];
  int unsigned   mdl_comp      [2][N];
  bit            granted       [2][N];

  function automatic int in_flight(input int d);
    return (mdl_tail[d] - mdl_head[d]) + (mdl_slot_v[d] ? 1 : 0);
  endfunction

  // A new descriptor is admitted only if the slot frees this cycle and the
  // total of issued-not-done plus slot stays within MO afterwards.
  function automatic int mdl_grant(input int d, input bit rdy);
    if (mdl_slot_v[d] && !rdy) return -1;
    if (in_flight(d) >= MO) return -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mdl_rr[d] + k) % N;
      if (req_valid[d][c]) return c;
    end
    return -1;
  endfunction

  task automatic mdl_reset();
    for (int d = 0; d < 2; d++) begin
      mdl_slot_v[d] = 1'b0;
      mdl_slot_ch[d] = 0;
      mdl_head[d] = 0;
      mdl_tail[d] = 0;
      mdl_rr[d] = 0;
      mdl_done[d] = '0;
      mdl_err[d] = 1'b0;
      for (int c = 0; c < N; c++) begin
        mdl_comp[d][c] = 0;
        granted[d][c] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0;
      m_ready[d] = 1'b0;
      m_done[d] = 1'b0;
    end
    repeat (2) @(posedge aclk);
    #1;
    mdl_reset();
    @(negedge aclk);
    check("rst_rd_ready", rd_ready, '0);
    check("rst_wr_ready", wr_ready, '0);
    check("rst_m_rd_valid", m_rd_valid, 1'b0);
    check("rst_m_wr_valid", m_wr_valid, 1'b0);
    check("rst_rd_done", rd_done, '0);
    check("rst_wr_done", wr_done, '0);
    check("rst_err", err, 2'b00);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic run_cycle(input int dens, input int rdy_pct, input int done_pct, input bit [1:0] spur);
    int g [2];
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N; c++) begin
        if (!req_valid[d][c] || granted[d][c]) begin
          req_valid[d][c] = ($urandom_range(0, 99) < dens);
          req_addr[d][c]  = AW'({$urandom, $urandom});
          req_len[d][c]   = LW'($urandom);
        end
      end
      m_ready[d] = ($urandom_range(0, 99) < rdy_pct);
      if (mdl_tail[d] != mdl_head[d]) m_done[d] = ($urandom_range(0, 99) < done_pct);
      else m_done[d] = spur[d];
    end

    @(negedge aclk);
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] exp_rdy;
      string        nm;
      nm = (d == 0) ? "rd" : "wr";
      g[d] = mdl_grant(d, m_ready[d]);
      exp_rdy = (g[d] >= 0) ? (N'(1) << g[d]) : '0;
      check({nm, "_ready"}, (d == 0) ? rd_ready : wr_ready, exp_rdy);
      check({nm, "_m_valid"}, (d == 0) ? m_rd_valid : m_wr_valid, mdl_slot_v[d]);
      if (mdl_slot_v[d]) begin
        check({nm, "_m_paddr"}, (d == 0) ? m_rd_paddr : m_wr_paddr, mdl_slot_addr[d]);
        check({nm, "_m_len"}, (d == 0) ? m_rd_len : m_wr_len, mdl_slot_len[d]);
      end
      check({nm, "_done"}, (d == 0) ? rd_done : wr_done, mdl_done[d]);
    end
    check("err", err, {mdl_err[1], mdl_err[0]});

    @(posedge aclk);
    for (int d = 0; d < 2; d++) begin
      bit issue;
      issue = mdl_slot_v[d] && m_ready[d];
      mdl_done[d] = '0;
      if (m_done[d]) begin
        if (mdl_tail[d] != mdl_head[d]) begin
          int h;
          h = mdl_tags[d][mdl_head[d] % QD];
          mdl_head[d]++;
          mdl_done[d][h] = 1'b1;
          mdl_comp[d][h]++;
        end else begin
          mdl_err[d] = 1'b1;
        end
      end
      if (issue) begin
        mdl_tags[d][mdl_tail[d] % QD] = mdl_slot_ch[d];
        mdl_tail[d]++;
        $display("[%0t] %s issue ch%0d paddr=0x%0h len=0x%0h outstanding=%0d",
                 $time, (d == 0) ? "rd" : "wr", mdl_slot_ch[d], mdl_slot_addr[d],
                 mdl_slot_len[d], mdl_tail[d] - mdl_head[d]);
      end
      if (g[d] >= 0) begin
        mdl_slot_v[d]    = 1'b1;
        mdl_slot_addr[d] = req_addr[d][g[d]];
        mdl_slot_len[d]  = req_len[d][g[d]];
        mdl_slot_ch[d]   = g[d];
        mdl_rr[d]        = (g[d] + 1) % N;
      end else if (issue) begin
        mdl_slot_v[d] = 1'b0;
      end
      for (int c = 0; c < N; c++) granted[d][c] = (g[d] == c);
    end
    #1;
  endtask

  task automatic run_phase(input int cycles, input int dens, input int rdy_pct,
                           input int done_pct, input bit [1:0] spur);
    for (int i = 0; i < cycles; i++) run_cycle(dens, rdy_pct, done_pct, spur);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = '0;
      m_ready[d] = 1'b0;
      m_done[d] = 1'b0;
      for (int c = 0; c < N; c++) begin
        req_addr[d][c] = '0;
        req_len[d][c] = '0;
      end
    end
`ifdef CDMA_MC_STATS_EN
    stat_sel = '0;
`endif
    mdl_reset();
    do_reset();

    // all channels busy, CDMA always ready: strict round-robin order
    run_phase(40, 100, 100, 60, 2'b00);
    // CDMA stalled: one descriptor held stable in the slot
    run_phase(10, 100, 0, 0, 2'b00);
    // CDMA accepts but never completes: credit fills and ready drops
    run_phase(20, 100, 100, 0, 2'b00);
    // completions at full credit, overlapping with issue
    run_phase(8, 100, 100, 100, 2'b00);
    // mixed random traffic on both directions
    run_phase(800, 50, 70, 40, 2'b00);
    // drain
    run_phase(40, 0, 100, 100, 2'b00);

`ifdef CDMA_MC_STATS_EN
    for (int c = 0; c < N; c++) begin
      stat_sel = 2'(c);
      run_phase(2, 0, 100, 100, 2'b00);
      check($sformatf("stat_rd_ch%0d", c), stat_rd_cnt, mdl_comp[0][c]);
      check($sformatf("stat_wr_ch%0d", c), stat_wr_cnt, mdl_comp[1][c]);
    end
`endif

    // completion on write with nothing outstanding
    run_phase(3, 0, 100, 0, 2'b10);
    run_phase(5, 0, 100, 0, 2'b00);
    check("err_wr_spurious", err, 2'b10);

    // reset mid-operation, then a stale read completion
    run_phase(30, 60, 70, 30, 2'b00);
    do_reset();
    run_phase(1, 0, 100, 0, 2'b01);
    run_phase(2, 0, 100, 0, 2'b00);
    check("err_rd_after_reset", err, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
